// File: rtl/sgd_adder_tree_accum_if.sv
// Beat-in / result-out stream bundle for the SGD adder-tree accumulator.
// slave is the accumulator side, master is the driving/consuming side.
interface sgd_adder_tree_accum_if #(
  parameter int NUM_LANES      = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BEAT_CNT_WIDTH = 16
);
  logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
  logic                            in_valid;
  logic                            in_last;
  logic                            in_ready;
  logic signed [DATA_WIDTH-1:0]    out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [BEAT_CNT_WIDTH-1:0]       out_beats;
  logic                            out_overflow;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_beats, out_overflow
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_beats, out_overflow
  );
endinterface

// File: rtl/sgd_adder_tree_accum.sv
// Pipelined signed reduction tree over NUM_LANES lanes followed by a
// multi-beat accumulator. One saturated sum per frame (closed by in_last).
// A single global enable freezes the whole pipe while a result is refused.
module sgd_adder_tree_accum #(
  parameter int NUM_LANES      = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  sgd_adder_tree_accum_if.slave bus
);
  localparam int TREE_DEPTH = (NUM_LANES < 2) ? 1 : $clog2(NUM_LANES);
  localparam int ACC_WIDTH  = DATA_WIDTH + TREE_DEPTH + BEAT_CNT_WIDTH;
  localparam int PAD        = 1 << TREE_DEPTH;
  localparam int HALF       = PAD / 2;
  localparam int TW         = DATA_WIDTH + TREE_DEPTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic                      en;
  logic [DATA_WIDTH-1:0]     lane [PAD];
  // Every level is held at the final tree width; level k only ever carries
  // DATA_WIDTH+k+1 significant bits, the rest is sign extension.
  logic [TW-1:0]             node_q [TREE_DEPTH][HALF];
  logic [TREE_DEPTH-1:0]     vld_q;
  logic [TREE_DEPTH-1:0]     lst_q;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] tree_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [BEAT_CNT_WIDTH-1:0]   cnt_q;
  logic [BEAT_CNT_WIDTH-1:0]   cnt_next;
  logic                        cnt_full;
  logic                        sticky_q;
  logic                        first_q;
  logic                        clip_hi;
  logic                        clip_lo;
  logic                        tree_vld;
  logic                        tree_lst;
  logic                        load;

  logic [DATA_WIDTH-1:0]     out_data_q;
  logic [BEAT_CNT_WIDTH-1:0] out_beats_q;
  logic                      out_ovf_q;
  logic                      out_valid_q;

  function automatic logic [TW-1:0] lane_ext(input logic [DATA_WIDTH-1:0] v);
    return {{TREE_DEPTH{v[DATA_WIDTH-1]}}, v};
  endfunction

  assign en           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = en;

  // Lanes beyond NUM_LANES are zero so the tree is always a full power of two.
  for (genvar i = 0; i < PAD; i++) begin : g_pad
    if (i < NUM_LANES) begin : g_lane
      assign lane[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_zero
      assign lane[i] = '0;
    end
  end

  // Tree data: pairwise sums, one register level per tree depth step.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int j = 0; j < HALF; j++)
        node_q[0][j] <= lane_ext(lane[2*j]) + lane_ext(lane[2*j+1]);
      for (int k = 1; k < TREE_DEPTH; k++) begin
        for (int j = 0; j < (HALF >> k); j++)
          node_q[k][j] <= node_q[k-1][2*j] + node_q[k-1][2*j+1];
        for (int j = (HALF >> k); j < HALF; j++)
          node_q[k][j] <= '0;
      end
    end
  end

  // valid/last shadow the tree data level by level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (en) begin
      vld_q[0] <= bus.in_valid;
      lst_q[0] <= bus.in_valid && bus.in_last;
      for (int k = 1; k < TREE_DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  assign tree_vld = vld_q[TREE_DEPTH-1];
  assign tree_lst = lst_q[TREE_DEPTH-1];
  assign tree_ext = {{(ACC_WIDTH-TW){node_q[TREE_DEPTH-1][0][TW-1]}}, node_q[TREE_DEPTH-1][0]};
  assign sum      = (first_q ? '0 : acc_q) + tree_ext;
  assign cnt_full = &cnt_q;
  assign cnt_next = cnt_full ? cnt_q : cnt_q + BEAT_CNT_WIDTH'(1);
  assign clip_hi  = sum > SAT_MAX;
  assign clip_lo  = sum < SAT_MIN;
  assign load     = en && tree_vld && tree_lst;

  // Running frame state: accumulator, beat count, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      first_q  <= 1'b1;
    end else if (en && tree_vld) begin
      if (!tree_lst) begin
        acc_q    <= sum;
        cnt_q    <= cnt_next;
        sticky_q <= sticky_q | cnt_full;
        first_q  <= 1'b0;
      end else begin
        acc_q    <= '0;
        cnt_q    <= '0;
        sticky_q <= 1'b0;
        first_q  <= 1'b1;
      end
    end
  end

  // Result register; a new frame result may replace an accepted one in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (load) begin
        out_data_q  <= clip_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                       clip_lo ? SAT_MIN[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
        out_ovf_q   <= clip_hi | clip_lo | sticky_q | cnt_full;
        out_beats_q <= cnt_next;
      end
      out_valid_q <= load || (out_valid_q && !bus.out_ready);
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_beats    = out_beats_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_valid    = out_valid_q;
endmodule

// File: tb/tb_sgd_adder_tree_accum.sv
// Bench for sgd_adder_tree_accum: directed frames plus a randomized run
// checked against a plain-arithmetic frame-sum model.
module tb_sgd_adder_tree_accum;
  localparam int L  = 16;
  localparam int L5 = 5;
  localparam int DW = 32;
  localparam int BW = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef logic [L*DW-1:0] beat16_t;
  typedef struct {
    logic [DW-1:0] data;
    int            beats;
    bit            ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   abort = 1'b0;

  always #5 clk = ~clk;

  sgd_adder_tree_accum_if #(.NUM_LANES(L),  .DATA_WIDTH(DW), .BEAT_CNT_WIDTH(BW)) b16 ();
  sgd_adder_tree_accum_if #(.NUM_LANES(L5), .DATA_WIDTH(DW), .BEAT_CNT_WIDTH(BW)) b5 ();

  sgd_adder_tree_accum #(.NUM_LANES(L),  .DATA_WIDTH(DW), .BEAT_CNT_WIDTH(BW)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(b16.slave));
  sgd_adder_tree_accum #(.NUM_LANES(L5), .DATA_WIDTH(DW), .BEAT_CNT_WIDTH(BW)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(b5.slave));

  function automatic longint lane_sum(input beat16_t d);
    longint s = 0;
    for (int i = 0; i < L; i++) s += longint'($signed(d[i*DW +: DW]));
    return s;
  endfunction

  function automatic exp_t model(input longint s, input int nb);
    exp_t e;
    e.beats = nb;
    e.ovf   = 1'b0;
    if (s > MAXV) begin e.data = 32'h7FFF_FFFF; e.ovf = 1'b1; end
    else if (s < MINV) begin e.data = 32'h8000_0000; e.ovf = 1'b1; end
    else e.data = s[DW-1:0];
    return e;
  endfunction

  function automatic beat16_t fill16(input logic [DW-1:0] v);
    beat16_t d;
    for (int i = 0; i < L; i++) d[i*DW +: DW] = v;
    return d;
  endfunction

  function automatic beat16_t rand_beat();
    beat16_t d;
    bit wide = ($urandom_range(0, 5) == 0);
    for (int i = 0; i < L; i++)
      d[i*DW +: DW] = wide ? DW'($urandom) : DW'(int'($urandom_range(0, 2000)) - 1000);
    return d;
  endfunction

  task automatic send16(input beat16_t d, input bit last);
    bit ok;
    b16.in_data  = d;
    b16.in_valid = 1'b1;
    b16.in_last  = last;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      ok = b16.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (t >= 2000) begin
        $display("FAIL send_timeout: in_ready stayed %0b, required 1", b16.in_ready);
        n_mis++;
        abort = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle16();
    b16.in_valid = 1'b0;
    b16.in_last  = 1'($urandom);
    b16.in_data  = rand_beat();
  endtask

  task automatic wait_out16();
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (b16.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      $display("FAIL out_timeout: out_valid stayed 0, required 1");
      n_mis++;
    end
  endtask

  task automatic test_reset();
    b16.in_valid = 0; b16.in_last = 0; b16.in_data = '0; b16.out_ready = 1;
    b5.in_valid = 0;  b5.in_last = 0;  b5.in_data = '0;  b5.out_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (b16.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %0b required 0", b16.out_valid); end
    n_cmp++; if (b16.out_data !== '0) begin n_mis++; $display("FAIL reset_out_data: got %0h required 0", b16.out_data); end
    n_cmp++; if (b16.out_beats !== '0) begin n_mis++; $display("FAIL reset_out_beats: got %0d required 0", b16.out_beats); end
    n_cmp++; if (b16.out_overflow !== 1'b0) begin n_mis++; $display("FAIL reset_out_overflow: got %0b required 0", b16.out_overflow); end
    n_cmp++; if (b16.in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %0b required 1", b16.in_ready); end
  endtask

  task automatic test_single_beat();
    beat16_t d;
    int lat;
    @(posedge clk); #1;
    for (int i = 0; i < L; i++) d[i*DW +: DW] = DW'(i + 1);
    b16.in_data = d; b16.in_valid = 1; b16.in_last = 1;
    @(posedge clk); #1;
    idle16();
    lat = 1;
    while (!b16.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 5) begin n_mis++; $display("FAIL single_latency: got %0d required 5", lat); end
    n_cmp++; if (b16.out_data !== 32'd136) begin n_mis++; $display("FAIL single_data: got %0d required 136", $signed(b16.out_data)); end
    n_cmp++; if (b16.out_beats !== 16'd1) begin n_mis++; $display("FAIL single_beats: got %0d required 1", b16.out_beats); end
    n_cmp++; if (b16.out_overflow !== 1'b0) begin n_mis++; $display("FAIL single_ovf: got %0b required 0", b16.out_overflow); end
    @(posedge clk); #1;
    n_cmp++; if (b16.out_valid !== 1'b0) begin n_mis++; $display("FAIL single_drop: got %0b required 0", b16.out_valid); end
  endtask

  task automatic test_padded();
    logic [L5*DW-1:0] d5;
    int v [5];
    bit ok = 1'b0;
    v = '{-3, 7, 0, 2, -1};
    for (int i = 0; i < L5; i++) d5[i*DW +: DW] = DW'(v[i]);
    @(posedge clk); #1;
    b5.in_data = d5; b5.in_valid = 1; b5.in_last = 0;
    for (int b = 1; b < 4; b++) begin
      @(posedge clk); #1;
      b5.in_data = '1; b5.in_last = (b == 3);
    end
    @(posedge clk); #1;
    b5.in_valid = 0; b5.in_last = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b5.out_valid) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL padded_valid: got 0 required 1"); end
    n_cmp++; if (b5.out_data !== -32'sd10) begin n_mis++; $display("FAIL padded_data: got %0d required -10", $signed(b5.out_data)); end
    n_cmp++; if (b5.out_beats !== 16'd4) begin n_mis++; $display("FAIL padded_beats: got %0d required 4", b5.out_beats); end
    n_cmp++; if (b5.out_overflow !== 1'b0) begin n_mis++; $display("FAIL padded_ovf: got %0b required 0", b5.out_overflow); end
  endtask

  task automatic test_saturation();
    beat16_t       fd [5];
    int            fn [5];
    logic [DW-1:0] fe [5];
    bit            fo [5];
    fd[0] = fill16(32'h7FFF_FFFF); fn[0] = 2; fe[0] = 32'h7FFF_FFFF; fo[0] = 1;
    fd[1] = fill16(32'h8000_0000); fn[1] = 1; fe[1] = 32'h8000_0000; fo[1] = 1;
    fd[2] = '0; fd[2][DW-1:0] = 32'h7FFF_FFFF; fn[2] = 1; fe[2] = 32'h7FFF_FFFF; fo[2] = 0;
    fd[3] = fd[2]; fd[3][2*DW-1:DW] = 32'd1; fn[3] = 1; fe[3] = 32'h7FFF_FFFF; fo[3] = 1;
    fd[4] = '0; fn[4] = 1; fe[4] = '0; fo[4] = 0;
    for (int f = 0; f < 5; f++) begin
      @(posedge clk); #1;
      for (int b = 0; b < fn[f]; b++) send16(fd[f], b == fn[f] - 1);
      idle16();
      wait_out16();
      n_cmp++; if (b16.out_data !== fe[f]) begin n_mis++; $display("FAIL sat_data[%0d]: got %0h required %0h", f, b16.out_data, fe[f]); end
      n_cmp++; if (b16.out_overflow !== fo[f]) begin n_mis++; $display("FAIL sat_ovf[%0d]: got %0b required %0b", f, b16.out_overflow, fo[f]); end
      n_cmp++; if (b16.out_beats !== BW'(fn[f])) begin n_mis++; $display("FAIL sat_beats[%0d]: got %0d required %0d", f, b16.out_beats, fn[f]); end
    end
  endtask

  task automatic test_back_to_back();
    beat16_t d [3];
    exp_t    e [3];
    @(posedge clk); #1;
    for (int f = 0; f < 3; f++) begin
      d[f] = rand_beat();
      e[f] = model(lane_sum(d[f]), 1);
      send16(d[f], 1'b1);
    end
    idle16();
    wait_out16();
    for (int f = 0; f < 3; f++) begin
      if (f > 0) @(negedge clk);
      n_cmp++; if (b16.out_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_valid[%0d]: got %0b required 1", f, b16.out_valid); end
      n_cmp++; if (b16.out_data !== e[f].data) begin n_mis++; $display("FAIL b2b_data[%0d]: got %0h required %0h", f, b16.out_data, e[f].data); end
    end
  endtask

  task automatic test_backpressure();
    beat16_t a, p1, p2;
    exp_t    ea, eb;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
    a = rand_beat(); p1 = rand_beat(); p2 = rand_beat();
    ea = model(lane_sum(a), 1);
    eb = model(lane_sum(p1) + lane_sum(p2), 2);
    send16(a, 1'b1);
    send16(p1, 1'b0);
    send16(p2, 1'b1);
    idle16();
    wait_out16();
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (b16.in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready[%0d]: got %0b required 0", c, b16.in_ready); end
      n_cmp++; if (b16.out_data !== ea.data) begin n_mis++; $display("FAIL bp_hold[%0d]: got %0h required %0h", c, b16.out_data, ea.data); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    b16.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (b16.out_data !== ea.data || b16.out_beats !== 16'd1) begin n_mis++; $display("FAIL bp_first: got %0h/%0d required %0h/1", b16.out_data, b16.out_beats, ea.data); end
    wait_out16();
    n_cmp++; if (b16.out_data !== eb.data) begin n_mis++; $display("FAIL bp_second_data: got %0h required %0h", b16.out_data, eb.data); end
    n_cmp++; if (b16.out_beats !== 16'd2) begin n_mis++; $display("FAIL bp_second_beats: got %0d required 2", b16.out_beats); end
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
    send16(rand_beat(), 1'b1);
    send16(rand_beat(), 1'b0);
    send16(rand_beat(), 1'b0);
    idle16();
    wait_out16();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (b16.out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_mid_valid: got %0b required 0", b16.out_valid); end
    n_cmp++; if (b16.out_data !== '0) begin n_mis++; $display("FAIL rst_mid_data: got %0h required 0", b16.out_data); end
    #2 rst_n = 1'b1;
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    send16(fill16(32'd2), 1'b1);
    idle16();
    wait_out16();
    n_cmp++; if (b16.out_data !== 32'd32) begin n_mis++; $display("FAIL rst_next_data: got %0d required 32", $signed(b16.out_data)); end
    n_cmp++; if (b16.out_beats !== 16'd1) begin n_mis++; $display("FAIL rst_next_beats: got %0d required 1", b16.out_beats); end
    n_cmp++; if (b16.out_overflow !== 1'b0) begin n_mis++; $display("FAIL rst_next_ovf: got %0b required 0", b16.out_overflow); end
  endtask

  task automatic test_random();
    exp_t q [$];
    @(posedge clk); #1;
    fork
      begin : driver
        for (int f = 0; f < 1000 && !abort; f++) begin
          int     nb = int'($urandom_range(1, 4));
          longint s  = 0;
          for (int b = 0; b < nb; b++) begin
            beat16_t d;
            if ($urandom_range(0, 3) == 0) begin idle16(); @(posedge clk); #1; end
            d = rand_beat();
            send16(d, b == nb - 1);
            s += lane_sum(d);
          end
          q.push_back(model(s, nb));
        end
        idle16();
      end
      begin : collector
        int            got = 0;
        bit            stalled = 1'b0;
        logic [DW-1:0] held = '0;
        exp_t          e;
        for (int cyc = 0; cyc < 40000 && got < 1000 && !abort; cyc++) begin
          b16.out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (stalled) begin
            n_cmp++;
            if (b16.out_valid !== 1'b1 || b16.out_data !== held) begin
              n_mis++;
              $display("FAIL rand_hold: got %0b/%0h required 1/%0h", b16.out_valid, b16.out_data, held);
            end
          end
          if (b16.out_valid) begin
            if (b16.out_ready) begin
              stalled = 1'b0;
              got++;
              n_cmp++;
              if (q.size() == 0) begin
                n_mis++;
                $display("FAIL rand_extra: got result %0h required none", b16.out_data);
              end else begin
                e = q.pop_front();
                if (b16.out_data !== e.data || b16.out_beats !== BW'(e.beats) || b16.out_overflow !== e.ovf) begin
                  n_mis++;
                  $display("FAIL rand_result[%0d]: got %0h/%0d/%0b required %0h/%0d/%0b", got,
                           b16.out_data, b16.out_beats, b16.out_overflow, e.data, e.beats, e.ovf);
                end
              end
            end else begin
              stalled = 1'b1;
              held = b16.out_data;
            end
          end
          @(posedge clk); #1;
        end
        if (got < 1000) begin
          n_mis++;
          $display("FAIL rand_count: got %0d results required 1000", got);
          abort = 1'b1;
        end
        b16.out_ready = 1'b1;
      end
    join
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_padded();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
